// File: rtl/noc_rr_packet_arbiter.sv
// N-input round-robin output-port arbiter for the NoC crossbar.
// Holds each grant for a whole packet; an optional watchdog frees stalled grants.
module noc_rr_packet_arbiter #(
    parameter int                NUM_PORTS   = 5,
    parameter int                LEN_W       = 12,
    parameter int                TYPE_W      = 3,
    parameter logic [TYPE_W-1:0] HEADER_CODE = 3'b001,
    parameter int                MAX_HOLD    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS*TYPE_W-1:0]   flit_type,
    input  logic [NUM_PORTS*LEN_W-1:0]    length,
    input  logic                          xfer,
    output logic [NUM_PORTS-1:0]          grant,
    output logic                          idle,
    output logic [$clog2(NUM_PORTS)-1:0]  grant_idx,
    output logic                          wd_abort
);

    localparam int IDX_W   = $clog2(NUM_PORTS);
    localparam int STALL_W = ($clog2(MAX_HOLD + 1) > 1) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic                 idle_q, idle_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic                 wd_abort_q, wd_abort_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     flit_cnt_q, flit_cnt_d;
    logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [TYPE_W-1:0]    win_type;
    logic [LEN_W-1:0]     win_len;
    logic [LEN_W-1:0]     win_len_eff;
    logic                 cur_req;
    logic                 tail;
    logic                 wd_hit;
    logic                 release_now;

    // Scan farthest-to-nearest so the nearest requester after grant_idx wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            int p;
            p = (int'(grant_idx_q) + k) % NUM_PORTS;
            if (req[IDX_W'(p)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(p);
            end
        end
    end

    // Non-header winners and zero lengths are treated as single-flit packets.
    always_comb begin
        win_type = flit_type[win_idx*TYPE_W +: TYPE_W];
        win_len  = length[win_idx*LEN_W +: LEN_W];
        if (win_type != HEADER_CODE || win_len == '0) begin
            win_len_eff = LEN_W'(1);
        end else begin
            win_len_eff = win_len;
        end
    end

    always_comb begin
        cur_req     = req[grant_idx_q];
        tail        = xfer && ((flit_cnt_q + LEN_W'(1)) == len_q);
        wd_hit      = (MAX_HOLD != 0) && !xfer
                      && ((int'(stall_cnt_q) + 1) == MAX_HOLD);
        release_now = tail || !cur_req || wd_hit;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        idle_d      = idle_q;
        grant_idx_d = grant_idx_q;
        wd_abort_d  = 1'b0;
        len_d       = len_q;
        flit_cnt_d  = flit_cnt_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d     = S_BUSY;
                    grant_d     = NUM_PORTS'(1) << win_idx;
                    idle_d      = 1'b0;
                    grant_idx_d = win_idx;
                    len_d       = win_len_eff;
                    flit_cnt_d  = '0;
                    stall_cnt_d = '0;
                end
            end
            S_BUSY: begin
                if (xfer) begin
                    flit_cnt_d  = flit_cnt_q + LEN_W'(1);
                    stall_cnt_d = '0;
                end else if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + STALL_W'(1);
                end
                if (release_now) begin
                    wd_abort_d = wd_hit && cur_req;
                    if (win_found) begin
                        grant_d     = NUM_PORTS'(1) << win_idx;
                        grant_idx_d = win_idx;
                        len_d       = win_len_eff;
                        flit_cnt_d  = '0;
                        stall_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = '0;
                        idle_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                idle_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            idle_q      <= 1'b1;
            grant_idx_q <= IDX_W'(NUM_PORTS - 1);
            wd_abort_q  <= 1'b0;
            len_q       <= LEN_W'(1);
            flit_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            idle_q      <= idle_d;
            grant_idx_q <= grant_idx_d;
            wd_abort_q  <= wd_abort_d;
            len_q       <= len_d;
            flit_cnt_q  <= flit_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign idle      = idle_q;
    assign grant_idx = grant_idx_q;
    assign wd_abort  = wd_abort_q;

endmodule

// File: tb/tb_noc_rr_packet_arbiter.sv
// Directed bench for noc_rr_packet_arbiter; expected outputs are queued
// by the driver and checked by an independent negedge monitor.
module tb_noc_rr_packet_arbiter;

    localparam int NP = 5;
    localparam int LW = 12;
    localparam int TW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NP-1:0]  req = '0;
    logic [NP*TW-1:0] flit_type;
    logic [NP*LW-1:0] length;
    logic           xfer = 1'b0;
    logic [NP-1:0]  grant;
    logic           idle;
    logic [2:0]     grant_idx;
    logic           wd_abort;

    noc_rr_packet_arbiter #(
        .NUM_PORTS  (NP),
        .LEN_W      (LW),
        .TYPE_W     (TW),
        .HEADER_CODE(3'b001),
        .MAX_HOLD   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .flit_type(flit_type),
        .length   (length),
        .xfer     (xfer),
        .grant    (grant),
        .idle     (idle),
        .grant_idx(grant_idx),
        .wd_abort (wd_abort)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int             cyc;
        int             id;
        logic [NP-1:0]  g;
        logic           i;
        logic [2:0]     x;
        logic           w;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int total = 0;
    int bad = 0;
    int step_id = 0;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc_cnt) begin
            mon_e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL step%0d: no output sampled for cycle %0d",
                     mon_e.id, mon_e.cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc_cnt) begin
            mon_e = sb.pop_front();
            total++;
            if (grant !== mon_e.g || idle !== mon_e.i ||
                grant_idx !== mon_e.x || wd_abort !== mon_e.w) begin
                bad++;
                $display("FAIL step%0d: got grant=%b idle=%b idx=%0d wd=%b want grant=%b idle=%b idx=%0d wd=%b",
                         mon_e.id, grant, idle, grant_idx, wd_abort,
                         mon_e.g, mon_e.i, mon_e.x, mon_e.w);
            end
        end
    end

    task automatic set_len(input int p, input int v);
        length[p*LW +: LW] = LW'(v);
    endtask

    task automatic set_type(input int p, input logic [TW-1:0] t);
        flit_type[p*TW +: TW] = t;
    endtask

    task automatic step(input logic r, input logic [NP-1:0] rq,
                        input logic x, input logic [NP-1:0] eg,
                        input logic ei, input logic [2:0] eidx,
                        input logic ew);
        exp_t e;
        rst  = r;
        req  = rq;
        xfer = x;
        step_id++;
        e.cyc = cyc_cnt + 1;
        e.id  = step_id;
        e.g   = eg;
        e.i   = ei;
        e.x   = eidx;
        e.w   = ew;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            set_type(p, 3'b001);
            set_len(p, 1);
        end
        @(posedge clk);
        #1;

        // single 3-flit packet, req dropped with the tail
        set_len(0, 3);
        step(1, 5'b00000, 0, 5'b00000, 1, 3'd4, 0);
        step(0, 5'b00001, 1, 5'b00001, 0, 3'd0, 0);
        step(0, 5'b00001, 1, 5'b00001, 0, 3'd0, 0);
        step(0, 5'b00001, 1, 5'b00001, 0, 3'd0, 0);
        step(0, 5'b00000, 1, 5'b00000, 1, 3'd0, 0);
        step(0, 5'b00000, 0, 5'b00000, 1, 3'd0, 0);

        // back-to-back rotation over inputs 1, 2, 4
        for (int p = 0; p < NP; p++) set_len(p, 1);
        step(1, 5'b00000, 0, 5'b00000, 1, 3'd4, 0);
        step(0, 5'b10110, 1, 5'b00010, 0, 3'd1, 0);
        step(0, 5'b10110, 1, 5'b00100, 0, 3'd2, 0);
        step(0, 5'b10110, 1, 5'b10000, 0, 3'd4, 0);
        step(0, 5'b10110, 1, 5'b00010, 0, 3'd1, 0);
        step(0, 5'b10110, 1, 5'b00100, 0, 3'd2, 0);
        step(0, 5'b00000, 1, 5'b00000, 1, 3'd2, 0);

        // packet hold, hand-over at the tail, sole-requester regain
        set_len(2, 4);
        set_len(1, 1);
        step(1, 5'b00000, 0, 5'b00000, 1, 3'd4, 0);
        step(0, 5'b00100, 0, 5'b00100, 0, 3'd2, 0);
        step(0, 5'b00100, 1, 5'b00100, 0, 3'd2, 0);
        step(0, 5'b00110, 1, 5'b00100, 0, 3'd2, 0);
        step(0, 5'b00110, 1, 5'b00100, 0, 3'd2, 0);
        step(0, 5'b00110, 1, 5'b00010, 0, 3'd1, 0);
        step(0, 5'b00010, 1, 5'b00010, 0, 3'd1, 0);
        step(0, 5'b00000, 0, 5'b00000, 1, 3'd1, 0);

        // request drop aborts; next search starts after input 3
        set_len(3, 10);
        set_len(4, 1);
        step(1, 5'b00000, 0, 5'b00000, 1, 3'd4, 0);
        step(0, 5'b01000, 0, 5'b01000, 0, 3'd3, 0);
        step(0, 5'b01000, 1, 5'b01000, 0, 3'd3, 0);
        step(0, 5'b01000, 1, 5'b01000, 0, 3'd3, 0);
        step(0, 5'b00000, 0, 5'b00000, 1, 3'd3, 0);
        step(0, 5'b10001, 0, 5'b10000, 0, 3'd4, 0);
        step(0, 5'b00000, 1, 5'b00000, 1, 3'd4, 0);

        // watchdog hand-over to the next requester
        set_len(0, 3);
        set_len(1, 2);
        set_len(2, 10);
        step(1, 5'b00000, 0, 5'b00000, 1, 3'd4, 0);
        step(0, 5'b00011, 0, 5'b00001, 0, 3'd0, 0);
        step(0, 5'b00011, 0, 5'b00001, 0, 3'd0, 0);
        step(0, 5'b00011, 0, 5'b00001, 0, 3'd0, 0);
        step(0, 5'b00011, 0, 5'b00001, 0, 3'd0, 0);
        step(0, 5'b00011, 0, 5'b00010, 0, 3'd1, 1);
        step(0, 5'b00010, 1, 5'b00010, 0, 3'd1, 0);
        step(0, 5'b00010, 1, 5'b00010, 0, 3'd1, 0);
        step(0, 5'b00000, 0, 5'b00000, 1, 3'd1, 0);

        // a transfer restarts the stall window; watchdog regain when sole
        step(0, 5'b00100, 0, 5'b00100, 0, 3'd2, 0);
        step(0, 5'b00100, 0, 5'b00100, 0, 3'd2, 0);
        step(0, 5'b00100, 0, 5'b00100, 0, 3'd2, 0);
        step(0, 5'b00100, 0, 5'b00100, 0, 3'd2, 0);
        step(0, 5'b00100, 1, 5'b00100, 0, 3'd2, 0);
        step(0, 5'b00100, 0, 5'b00100, 0, 3'd2, 0);
        step(0, 5'b00100, 0, 5'b00100, 0, 3'd2, 0);
        step(0, 5'b00100, 0, 5'b00100, 0, 3'd2, 0);
        step(0, 5'b00100, 0, 5'b00100, 0, 3'd2, 1);
        step(0, 5'b00000, 0, 5'b00000, 1, 3'd2, 0);

        // reset mid-packet restores input-0 priority
        set_len(4, 10);
        step(1, 5'b00000, 0, 5'b00000, 1, 3'd4, 0);
        step(0, 5'b10000, 1, 5'b10000, 0, 3'd4, 0);
        step(0, 5'b10000, 1, 5'b10000, 0, 3'd4, 0);
        step(1, 5'b11111, 1, 5'b00000, 1, 3'd4, 0);
        step(0, 5'b11111, 1, 5'b00001, 0, 3'd0, 0);

        // non-header and zero-length winners act as single flits
        set_type(1, 3'b010);
        set_len(1, 8);
        set_len(2, 0);
        step(1, 5'b00000, 0, 5'b00000, 1, 3'd4, 0);
        step(0, 5'b00110, 0, 5'b00010, 0, 3'd1, 0);
        step(0, 5'b00110, 1, 5'b00100, 0, 3'd2, 0);
        step(0, 5'b00110, 1, 5'b00010, 0, 3'd1, 0);
        step(0, 5'b00000, 1, 5'b00000, 1, 3'd1, 0);

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_rr_packet_arbiter.md
Name: noc_rr_packet_arbiter

Overview:
Parametrised output-port arbiter for the NoC router crossbar. It replaces the fixed three-input, per-port-timer arbiter with an N-input round-robin arbiter.
- The last-served input gets the least priority.
- A grant is held for a whole packet, counted in transferred flits against the length latched from the header.
- An optional stall watchdog forces release of a stuck grant.
- One instance sits per output port, between the input-buffer request logic and the crossbar select.

Parameters:
NUM_PORTS, 5, number of requesting inputs (index 0 = Local, 1 = North, 2 = East, 3 = South, 4 = West)
LEN_W, 12, width of the packet-length field, in flits
TYPE_W, 3, width of the flit-type field
HEADER_CODE, 3'b001, flit-type encoding of a header flit (instantiations pass the project HEADER define)
MAX_HOLD, 0, maximum consecutive cycles a grant may be held with no transfer before forced release; 0 disables the watchdog

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
req  input  NUM_PORTS  per-input request for this output
flit_type  input  NUM_PORTS*TYPE_W  head-flit type per input; input i occupies bits [i*TYPE_W +: TYPE_W]
length  input  NUM_PORTS*LEN_W  packet length per input, valid when that input's head flit is a header
xfer  input  1  one flit of the granted input crosses the crossbar this cycle
grant  output  NUM_PORTS  registered one-hot grant; all zero when idle
idle  output  1  registered, high when no grant is active
grant_idx  output  $clog2(NUM_PORTS)  registered index of the current or most recent grant
wd_abort  output  1  registered one-cycle pulse when the watchdog forces a release

Behaviour:
- Reset: grant=0, idle=1, grant_idx=NUM_PORTS-1 (so input 0 has top priority after reset), wd_abort=0, flit count=0, stall count=0.
- Reset mid-packet drops the grant at the next edge. The next arbitration starts fresh from input 0 priority.
- State machine: IDLE and BUSY.
- Arbitration function: scan starts at grant_idx+1 mod NUM_PORTS and wraps. The first asserted req wins.
- IDLE, any req high: the winner's grant bit is set at the next edge. At the same edge:
  - grant_idx ← winner; state → BUSY.
  - len_q ← length of the winner (a value of 0 is stored as 1).
  - Flit count and stall count clear to 0.
- IDLE, no req: stay in IDLE.
- Latency: req to grant is one cycle. No combinational path exists from any input to any output.
- BUSY, per cycle:
  - xfer=1: flit count increments. The stall count clears.
  - xfer=0: the stall count increments, saturating.
  - xfer while grant is low is ignored.
- BUSY release conditions, evaluated in priority order:
  - (a) Tail: xfer=1 and flit count+1 == len_q.
  - (b) Abort: req of the granted input is low.
  - (c) Watchdog: MAX_HOLD≠0 and stall count+1 == MAX_HOLD with xfer=0. wd_abort pulses the next cycle.
- On release, re-arbitrate in the same cycle with grant_idx as the least-priority input.
  - If a winner exists, the grant moves to it at that edge (no idle bubble), and len_q and the counters reload.
  - If no req is high, go to IDLE: grant=0 and idle=1 next cycle.
- The released input regains the grant only if it is the sole requester.
- Header-type check: a winner whose flit_type is not HEADER_CODE still receives the grant, with len_q=1 (single-flit protection).
- Widths:
  - Flit count is LEN_W bits. len_q never exceeds 2^LEN_W-1, so there is no overflow.
  - Stall count is max(1,$clog2(MAX_HOLD+1)) bits.
- Simultaneous tail and req drop on the granted input count as a tail release; the result is identical.

Test Plan:
1. Reset, then req=5'b00001, length[0]=3, xfer held at 1 → grant=00001 from cycle 1 to cycle 3; after the third xfer, grant=0 and idle=1.
2. req=5'b10110 from reset with all lengths=1 and xfer=1 → grants rotate 00010, 00100, 10000, 00010, …, one per cycle with no idle gaps.
3. Input 2 granted with length=4, and input 1 raises req mid-packet → grant stays 00100 for 4 transfers, then moves to 00010 at the same edge the tail transfers.
4. Input 3 granted with length=10, and req[3] drops after 2 transfers → grant releases the next edge; grant_idx=3; the next winner is searched from input 4.
5. MAX_HOLD=4, input 0 granted, xfer=0 for 4 cycles → release at the 4th stall cycle, wd_abort=1 for exactly one cycle, grant moves to the next requester or to idle.
6. Assert rst while in BUSY with input 4 granted → the next cycle shows grant=0, idle=1, grant_idx=4 (NUM_PORTS-1); with req=11111, the next grant is 00001.
